// File: rtl/mode_selector_if.sv
// rtl/mode_selector_if.sv - command byte and mode enables between the Arduino link and the mode arbiter
interface mode_selector_if;
  logic [7:0] arduino_command;
  logic       manual_on;
  logic       auto_on;

  modport master (
    output arduino_command,
    input  manual_on,
    input  auto_on
  );

  modport slave (
    input  arduino_command,
    output manual_on,
    output auto_on
  );
endinterface

// File: rtl/mode_selector.sv
// rtl/mode_selector.sv - Moore arbiter choosing manual or autonomous operation from the command byte
module mode_selector #(
  parameter logic [7:0] MANUAL_CMD = 8'h00,
  parameter logic [7:0] AUTO_CMD   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  mode_selector_if.slave    bus
);

  typedef enum logic [1:0] {
    Initialise = 2'b00,
    Manual     = 2'b01,
    Auto       = 2'b10
  } mode_state_t;

  mode_state_t current_state;
  mode_state_t next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_state <= Initialise;
    end else begin
      current_state <= next_state;
    end
  end

  // Only the exact code of the other mode moves the FSM; every other byte is ignored.
  always_comb begin
    next_state = current_state;
    case (current_state)
      Initialise: next_state = Manual;
      Manual: begin
        if (bus.arduino_command == AUTO_CMD) begin
          next_state = Auto;
        end
      end
      Auto: begin
        if (bus.arduino_command == MANUAL_CMD) begin
          next_state = Manual;
        end
      end
      default: next_state = Initialise;
    endcase
  end

  // Enables decode from state alone, so they can never both be high.
  always_comb begin
    bus.manual_on = 1'b0;
    bus.auto_on   = 1'b0;
    case (current_state)
      Manual:  bus.manual_on = 1'b1;
      Auto:    bus.auto_on   = 1'b1;
      default: begin
        bus.manual_on = 1'b0;
        bus.auto_on   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mode_selector.sv
// tb/tb_mode_selector.sv - directed self-checking bench for mode_selector
module tb_mode_selector;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  mode_selector_if bus ();

  mode_selector #(
    .MANUAL_CMD (8'h00),
    .AUTO_CMD   (8'hFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string obs, input string exp);
    n_compared++;
    if (obs != exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %s, expected %s", tag, obs, exp);
    end
  endtask

  task automatic expect_mode(input string tag, input string st, input logic man, input logic aut);
    check({tag, ".state"}, dut.current_state.name(), st);
    check({tag, ".manual_on"}, $sformatf("%0b", bus.manual_on), $sformatf("%0b", man));
    check({tag, ".auto_on"}, $sformatf("%0b", bus.auto_on), $sformatf("%0b", aut));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step(input logic [7:0] cmd);
    bus.arduino_command = cmd;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] junk [4];

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    junk[0] = 8'h0F;
    junk[1] = 8'hFE;
    junk[2] = 8'h01;
    junk[3] = 8'h80;

    rst_n = 1'b0;
    bus.arduino_command = 8'h00;
    repeat (2) @(posedge clk);
    #3;
    expect_mode("in_reset", "Initialise", 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    expect_mode("released", "Initialise", 1'b0, 1'b0);

    step(8'h00);
    expect_mode("first_edge", "Manual", 1'b1, 1'b0);
    step(8'h00);
    expect_mode("manual_hold", "Manual", 1'b1, 1'b0);

    step(8'hFF);
    expect_mode("to_auto", "Auto", 1'b0, 1'b1);
    step(8'hFF);
    expect_mode("auto_hold", "Auto", 1'b0, 1'b1);
    step(8'h00);
    expect_mode("to_manual", "Manual", 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      step(junk[i]);
      expect_mode($sformatf("manual_junk_%h", junk[i]), "Manual", 1'b1, 1'b0);
    end

    step(8'hFF);
    expect_mode("to_auto2", "Auto", 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(junk[i]);
      expect_mode($sformatf("auto_junk_%h", junk[i]), "Auto", 1'b0, 1'b1);
    end

    step(8'h00);
    expect_mode("toggle_0", "Manual", 1'b1, 1'b0);
    step(8'hFF);
    expect_mode("toggle_1", "Auto", 1'b0, 1'b1);
    step(8'h00);
    expect_mode("toggle_2", "Manual", 1'b1, 1'b0);
    step(8'hFF);
    expect_mode("toggle_3", "Auto", 1'b0, 1'b1);

    // Asynchronous reset asserted mid-cycle while in Auto.
    #2;
    rst_n = 1'b0;
    #1;
    expect_mode("async_reset", "Initialise", 1'b0, 1'b0);
    step(8'hFF);
    expect_mode("reset_held_edge", "Initialise", 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    expect_mode("rerelease", "Initialise", 1'b0, 1'b0);
    step(8'hFF);
    expect_mode("ff_edge1", "Manual", 1'b1, 1'b0);
    step(8'hFF);
    expect_mode("ff_edge2", "Auto", 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
